// File: rtl/down_counter_161r.sv
// down_counter_161r: synchronous presettable down-counter with a borrow
// output and optional auto-reload. It is the down-counting counterpart of
// the 4-bit up-counter and keeps the same enable, load and data port names.
// Stages cascade through CTT/CTP and BO to form wider counters.
module down_counter_161r #(
  parameter int WIDTH = 4
) (
  input  logic             CP,
  input  logic             CR,
  input  logic             Ld,
  input  logic             CTT,
  input  logic             CTP,
  input  logic             AR,
  input  logic [WIDTH-1:0] D,
  output logic [WIDTH-1:0] Q,
  output logic             BO,
  output logic             ZP
);

  // Reload value, captured on every parallel load and cleared by CR.
  logic [WIDTH-1:0] rv;

  // Terminal count is seen on the registered count only.
  logic q_zero;
  assign q_zero = (Q == '0);

  // Count state. Priority is clear, then load, then count, then hold.
  // ZP is set only on the edge that leaves terminal count while counting.
  always_ff @(posedge CP) begin
    if (CR) begin
      Q  <= '0;
      rv <= '0;
      ZP <= 1'b0;
    end else if (Ld) begin
      Q  <= D;
      rv <= D;
      ZP <= 1'b0;
    end else if (CTT && CTP) begin
      rv <= rv;
      if (!q_zero) begin
        Q  <= Q - WIDTH'(1);
        ZP <= 1'b0;
      end else begin
        // AR is sampled only here, so changing it mid-count has no effect
        // until the next terminal-count edge.
        Q  <= AR ? rv : '1;
        ZP <= 1'b1;
      end
    end else begin
      Q  <= Q;
      rv <= rv;
      ZP <= 1'b0;
    end
  end

  // Borrow ignores CTP so the next stage's CTT can be driven straight from BO.
  assign BO = CTT & q_zero;

endmodule

// File: tb/tb_down_counter_161r.sv
// Scoreboard bench for down_counter_161r: stimulus pushes hand-computed
// expectations, a monitor pops one per cycle and compares after the edge.
module tb_down_counter_161r;

  logic       clk = 1'b0;
  logic       cr = 1'b1, ld = 1'b0, ctt = 1'b0, ctp = 1'b0, ar = 1'b0;
  logic [3:0] d = 4'h0;
  logic [3:0] q;
  logic       bo, zp;

  // Cascade pair: lower stage always enabled on CTT, upper CTT from lower BO.
  logic       c_cr = 1'b1, c_ld = 1'b0, c_ctp = 1'b0, c_ar = 1'b0;
  logic [3:0] c_d = 4'h0;
  logic [3:0] q_lo, q_hi;
  logic       bo_lo, bo_hi, zp_lo, zp_hi;

  always #5 clk = ~clk;

  down_counter_161r #(.WIDTH(4)) u_dut (
    .CP(clk), .CR(cr), .Ld(ld), .CTT(ctt), .CTP(ctp), .AR(ar),
    .D(d), .Q(q), .BO(bo), .ZP(zp)
  );

  down_counter_161r #(.WIDTH(4)) u_lo (
    .CP(clk), .CR(c_cr), .Ld(c_ld), .CTT(1'b1), .CTP(c_ctp), .AR(c_ar),
    .D(c_d), .Q(q_lo), .BO(bo_lo), .ZP(zp_lo)
  );

  down_counter_161r #(.WIDTH(4)) u_hi (
    .CP(clk), .CR(c_cr), .Ld(c_ld), .CTT(bo_lo), .CTP(c_ctp), .AR(c_ar),
    .D(c_d), .Q(q_hi), .BO(bo_hi), .ZP(zp_hi)
  );

  typedef struct {
    logic [7:0] q;
    logic       zp;
    logic       bo;
    bit         casc;
    string      name;
  } exp_t;

  exp_t sb[$];
  int   vectors = 0;
  int   miscompares = 0;

  // Drive one cycle of single-counter inputs and queue the state expected
  // after the following rising edge (BO uses the CTT driven here).
  task automatic step(input logic i_cr, input logic i_ld, input logic i_ctt,
                      input logic i_ctp, input logic i_ar, input logic [3:0] i_d,
                      input logic [3:0] e_q, input logic e_zp, input logic e_bo,
                      input string name);
    exp_t e;
    @(negedge clk);
    cr = i_cr; ld = i_ld; ctt = i_ctt; ctp = i_ctp; ar = i_ar; d = i_d;
    e.q = {4'h0, e_q}; e.zp = e_zp; e.bo = e_bo; e.casc = 1'b0; e.name = name;
    sb.push_back(e);
  endtask

  task automatic cstep(input logic i_cr, input logic i_ld, input logic i_ctp,
                       input logic [7:0] e_q, input logic e_zp, input logic e_bo,
                       input string name);
    exp_t e;
    @(negedge clk);
    c_cr = i_cr; c_ld = i_ld; c_ctp = i_ctp; c_ar = 1'b0; c_d = 4'h0;
    e.q = e_q; e.zp = e_zp; e.bo = e_bo; e.casc = 1'b1; e.name = name;
    sb.push_back(e);
  endtask

  // Monitor: every cycle the DUT presents a new registered state.
  always @(posedge clk) begin
    #1;
    if (sb.size() > 0) begin
      exp_t       e;
      logic [7:0] a_q;
      logic       a_zp, a_bo;
      e    = sb.pop_front();
      a_q  = e.casc ? {q_hi, q_lo} : {4'h0, q};
      a_zp = e.casc ? zp_hi : zp;
      a_bo = e.casc ? bo_hi : bo;
      vectors++;
      if (a_q !== e.q || a_zp !== e.zp || a_bo !== e.bo) begin
        miscompares++;
        $display("FAIL %s: got q=%h zp=%b bo=%b, want q=%h zp=%b bo=%b",
                 e.name, a_q, a_zp, a_bo, e.q, e.zp, e.bo);
      end
    end
  end

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog: bench did not finish, got timeout, want completion");
    $fatal(1);
  end

  initial begin
    logic [7:0] comb;
    // 1: clear dominates load and enables; BO follows CTT at zero.
    step(1, 1, 1, 1, 0, 4'hD, 4'd0, 0, 1, "clr0");
    step(1, 1, 1, 1, 0, 4'hD, 4'd0, 0, 1, "clr1");
    step(0, 0, 0, 0, 0, 4'h0, 4'd0, 0, 0, "clr_ctt0");

    // 2: load 5, free-run with wrap to all-ones.
    step(0, 1, 1, 1, 0, 4'd5, 4'd5, 0, 0, "ld5");
    step(0, 0, 1, 1, 0, 4'd0, 4'd4, 0, 0, "wrap4");
    step(0, 0, 1, 1, 0, 4'd0, 4'd3, 0, 0, "wrap3");
    step(0, 0, 1, 1, 0, 4'd0, 4'd2, 0, 0, "wrap2");
    step(0, 0, 1, 1, 0, 4'd0, 4'd1, 0, 0, "wrap1");
    step(0, 0, 1, 1, 0, 4'd0, 4'd0, 0, 1, "wrap0");
    step(0, 0, 1, 1, 0, 4'd0, 4'd15, 1, 0, "wrap15");
    step(0, 0, 1, 1, 0, 4'd0, 4'd14, 0, 0, "wrap14");

    // 3: auto-reload from 3 -> divide by 4.
    step(0, 1, 1, 1, 1, 4'd3, 4'd3, 0, 0, "ld3");
    for (int k = 1; k <= 12; k++) begin
      logic [3:0] eq;
      eq = 4'(3 - (k % 4));
      step(0, 0, 1, 1, 1, 4'd0, eq, (k % 4) == 0, eq == 4'd0, "reload");
    end

    // 4: CTP gating.
    step(0, 1, 1, 1, 0, 4'd6, 4'd6, 0, 0, "ld6");
    step(0, 0, 1, 1, 0, 4'd0, 4'd5, 0, 0, "ctp1a");
    step(0, 0, 1, 0, 0, 4'd0, 4'd5, 0, 0, "ctp0a");
    step(0, 0, 1, 1, 0, 4'd0, 4'd4, 0, 0, "ctp1b");
    step(0, 0, 1, 0, 0, 4'd0, 4'd4, 0, 0, "ctp0b");

    // 5: load beats terminal count; RV=0 gives divide-by-1.
    step(0, 1, 1, 1, 0, 4'd1, 4'd1, 0, 0, "ld1");
    step(0, 0, 1, 1, 0, 4'd0, 4'd0, 0, 1, "to0");
    step(0, 1, 1, 1, 0, 4'd9, 4'd9, 0, 0, "ld_at0");
    step(0, 1, 1, 1, 1, 4'd0, 4'd0, 0, 1, "ld0");
    step(0, 0, 1, 1, 1, 4'd0, 4'd0, 1, 1, "div1a");
    step(0, 0, 1, 1, 1, 4'd0, 4'd0, 1, 1, "div1b");
    step(0, 0, 1, 1, 1, 4'd0, 4'd0, 1, 1, "div1c");
    // clear during a ZP pulse, then reload yields 0 since RV was cleared
    step(1, 0, 1, 1, 1, 4'd0, 4'd0, 0, 1, "clr_zp");
    step(0, 1, 1, 1, 0, 4'd2, 4'd2, 0, 0, "ld2");
    step(0, 0, 1, 1, 0, 4'd0, 4'd1, 0, 0, "ar_late1");
    step(0, 0, 1, 1, 0, 4'd0, 4'd0, 0, 1, "ar_late0");
    step(0, 0, 1, 1, 1, 4'd0, 4'd2, 1, 0, "ar_late_reload");
    step(1, 0, 1, 1, 1, 4'd0, 4'd0, 0, 1, "clr_rv");
    step(0, 0, 1, 1, 1, 4'd0, 4'd0, 1, 1, "reload_after_clr");

    // 6: cascaded pair behaves as an 8-bit down-counter.
    cstep(1, 0, 0, 8'h00, 0, 1, "c_clr");
    cstep(0, 1, 1, 8'h00, 0, 1, "c_ld0");
    for (int k = 1; k <= 384; k++) begin
      comb = 8'(256 - (k % 256));
      cstep(0, 0, 1, comb, comb == 8'hFF, comb == 8'h00, "casc");
    end
    cstep(1, 0, 1, 8'h00, 0, 1, "c_clr_mid");

    @(posedge clk);
    #3;
    if (sb.size() != 0) begin
      miscompares++;
      $display("FAIL drain: got %0d pending, want 0", sb.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
